// File: rtl/clock_step_ctrl.sv
`default_nettype none
// ============================================================================
// clock_step_ctrl : run/step/halt controller driving the CPU datapath enable
// Rev 1.0
// ============================================================================
module clock_step_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 8,
  parameter int DIV_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic [DIV_W-1:0]  div,
  input  logic              halt_req,
  output logic              cmd_ready,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              step_done,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [STEP_W-1:0] REM_ONE = STEP_W'(1);

  logic [DIV_W-1:0]  r_pre;
  logic [DIV_W-1:0]  w_pre_nxt;
  logic [STEP_W-1:0] r_remaining;
  logic [STEP_W-1:0] w_rem_nxt;
  logic [1:0]        w_state_nxt;
  logic              w_done_nxt;
  logic              w_active;
  logic              w_cmd_halt;
  logic              w_cmd_run;
  logic              w_cmd_step;
  logic              w_cmd_clear;
  logic              w_cpu_halt;
  logic              w_stop;
  logic              w_fire;

  assign cmd_ready   = 1'b1;
  assign w_active    = (state == S_RUN) || (state == S_STEP);
  assign w_cmd_halt  = cmd_valid && (cmd_op == OP_HALT);
  assign w_cmd_run   = cmd_valid && (cmd_op == OP_RUN);
  assign w_cmd_step  = cmd_valid && (cmd_op == OP_STEP);
  assign w_cmd_clear = cmd_valid && (cmd_op == OP_CLEAR);
  assign w_cpu_halt  = halt_req && w_active;
  assign w_stop      = w_cmd_halt || w_cpu_halt;
  assign w_fire      = w_active && (r_pre >= div) && !w_stop;

  // The >= compare also recovers when div is lowered below the current count.
  assign w_pre_nxt = (!w_active || (r_pre >= div)) ? '0 : r_pre + 1'b1;

  always_comb begin
    w_state_nxt = state;
    w_rem_nxt   = r_remaining;
    w_done_nxt  = 1'b0;

    if (w_cpu_halt) begin
      w_state_nxt = S_HALT;
    end else if (w_cmd_halt) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = '0;
    end else if (w_cmd_run) begin
      w_state_nxt = S_RUN;
      if (state == S_STEP) begin
        w_rem_nxt = '0;
      end
    end else if (w_cmd_step) begin
      if (!w_active && (cmd_arg != '0)) begin
        w_state_nxt = S_STEP;
        w_rem_nxt   = cmd_arg;
      end
    end

    // A RUN arriving during a step sequence takes over from the sequencer.
    if (w_fire && (state == S_STEP) && !w_cmd_run) begin
      w_rem_nxt = r_remaining - 1'b1;
      if (r_remaining == REM_ONE) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cpu_en      <= 1'b0;
      step_done   <= 1'b0;
      cycle_count <= '0;
      r_pre       <= '0;
      r_remaining <= '0;
    end else begin
      state       <= w_state_nxt;
      cpu_en      <= w_fire;
      step_done   <= w_done_nxt;
      r_pre       <= w_pre_nxt;
      r_remaining <= w_rem_nxt;
      if (w_cmd_clear) begin
        cycle_count <= '0;
      end else if (cpu_en && (cycle_count != CNT_MAX)) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_step_ctrl.sv
`default_nettype none
// ============================================================================
// tb_clock_step_ctrl : directed + randomized bench with a behavioural model
// Rev 1.0
// ============================================================================
module tb_clock_step_ctrl;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op    = 2'b00;
  logic [7:0] cmd_arg   = 8'd0;
  logic [3:0] div       = 4'd0;
  logic       halt_req  = 1'b0;

  logic        cmd_ready, cpu_en, step_done;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic        s_ready, s_en, s_done;
  logic [1:0]  s_state;
  logic [3:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #10 clk = ~clk;

  clock_step_ctrl #(.CNT_W(32), .STEP_W(8), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .div(div), .halt_req(halt_req), .cmd_ready(cmd_ready),
    .cpu_en(cpu_en), .state(state), .step_done(step_done), .cycle_count(cycle_count)
  );

  clock_step_ctrl #(.CNT_W(4), .STEP_W(8), .DIV_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .div(div), .halt_req(halt_req), .cmd_ready(s_ready),
    .cpu_en(s_en), .state(s_state), .step_done(s_done), .cycle_count(s_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as plain ints, updated from the rule list each edge.
  int     m_state = 0;
  int     m_pre   = 0;
  int     m_rem   = 0;
  bit     m_en    = 1'b0;
  bit     m_done  = 1'b0;
  longint m_cnt   = 0;
  int     m_cnt4  = 0;
  bit     mo_act, mo_stop, mo_fire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_pre = 0; m_rem = 0; m_en = 1'b0; m_done = 1'b0;
      m_cnt = 0; m_cnt4 = 0;
    end else begin
      mo_act  = (m_state == 1) || (m_state == 2);
      mo_stop = (cmd_valid && cmd_op == 2'd0) || (halt_req && mo_act);
      mo_fire = mo_act && (m_pre >= int'(div)) && !mo_stop;
      if (cmd_valid && cmd_op == 2'd3) begin
        m_cnt = 0; m_cnt4 = 0;
      end else if (m_en) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_pre  = (mo_act && m_pre < int'(div)) ? m_pre + 1 : 0;
      m_done = 1'b0;
      if (halt_req && mo_act) begin
        m_state = 3;
      end else if (cmd_valid) begin
        case (cmd_op)
          2'd0: begin m_state = 0; m_rem = 0; end
          2'd1: begin if (m_state == 2) m_rem = 0; m_state = 1; end
          2'd2: if (!mo_act && cmd_arg != 8'd0) begin m_state = 2; m_rem = int'(cmd_arg); end
          default: ;
        endcase
      end
      if (mo_fire && m_state == 2) begin
        m_rem--;
        if (m_rem == 0) begin m_state = 0; m_done = 1'b1; end
      end
      m_en = mo_fire;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("state", state, m_state);
      check("cpu_en", cpu_en, m_en);
      check("step_done", step_done, m_done);
      check("cycle_count", cycle_count, m_cnt);
      check("cmd_ready", cmd_ready, 1);
      check("small_state", s_state, m_state);
      check("small_cpu_en", s_en, m_en);
      check("small_step_done", s_done, m_done);
      check("small_cycle_count", s_count, m_cnt4);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  int pulses;
  int r;

  initial begin
    #25 rst_n = 1'b1;
    @(negedge clk);
    cmp_on = 1'b1;

    // Reset and release
    for (int i = 0; i < 5; i++) begin
      check("rst_state", state, 0);
      check("rst_cpu_en", cpu_en, 0);
      check("rst_count", cycle_count, 0);
      check("rst_ready", cmd_ready, 1);
      tick();
    end

    // Continuous run, div=0
    div = 4'd0;
    send(2'd1, 8'd0);
    check("run_state", state, 1);
    check("run_first_en_low", cpu_en, 0);
    tick();
    check("run_en_on", cpu_en, 1);
    check("run_count0", cycle_count, 0);
    repeat (9) tick();
    check("run_en_held", cpu_en, 1);
    check("run_count9", cycle_count, 9);
    send(2'd0, 8'd0);
    check("halt_state", state, 0);
    check("halt_en", cpu_en, 0);
    check("halt_count", cycle_count, 10);
    tick();
    check("halt_count_held", cycle_count, 10);

    // Divided step, div=2, 3 steps
    send(2'd3, 8'd0);
    check("clear_count", cycle_count, 0);
    div = 4'd2;
    send(2'd2, 8'd3);
    check("step_state", state, 2);
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cpu_en === 1'b1) pulses++;
      check("step_en_pattern", cpu_en, ((i % 3 == 0) && (i <= 9)) ? 1 : 0);
      check("step_done_pattern", step_done, (i == 9) ? 1 : 0);
    end
    check("step_pulses", pulses, 3);
    check("step_end_state", state, 0);
    check("step_count", cycle_count, 3);

    // CPU halt beats a simultaneous STEP command
    div = 4'd0;
    send(2'd3, 8'd0);
    send(2'd1, 8'd0);
    repeat (4) tick();
    check("pre_halt_en", cpu_en, 1);
    halt_req = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 8'd5;
    tick();
    halt_req = 1'b0; cmd_valid = 1'b0;
    check("cpu_halt_state", state, 3);
    check("cpu_halt_en", cpu_en, 0);
    tick();
    check("cpu_halt_persist", state, 3);
    send(2'd1, 8'd0);
    check("resume_state", state, 1);
    send(2'd0, 8'd0);

    // Saturation of the 4-bit counter, then CLEAR while enabled
    send(2'd3, 8'd0);
    send(2'd1, 8'd0);
    repeat (20) tick();
    check("sat_count4", s_count, 15);
    check("sat_en", s_en, 1);
    send(2'd3, 8'd0);
    check("clear_while_en4", s_count, 0);
    check("clear_while_en32", cycle_count, 0);
    tick();
    check("count_after_clear", s_count, 1);
    send(2'd0, 8'd0);

    // Asynchronous reset in the middle of a 10-step sequence
    send(2'd2, 8'd10);
    repeat (4) tick();
    check("mid_step_en", cpu_en, 1);
    #5 rst_n = 1'b0;
    #1;
    check("arst_en", cpu_en, 0);
    check("arst_state", state, 0);
    check("arst_done", step_done, 0);
    check("arst_count", cycle_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_arst_done", step_done, 0);
      check("post_arst_en", cpu_en, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 25);
      r = int'($urandom_range(0, 9));
      cmd_op = (r == 0) ? 2'd0 : (r <= 3) ? 2'd1 : (r <= 7) ? 2'd2 : 2'd3;
      if (cmd_op == 2'd1 && m_state == 2) cmd_op = 2'd3;
      cmd_arg  = 8'($urandom_range(0, 6));
      halt_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) div = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #4 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    halt_req  = 1'b0;
    tick();
    cmp_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
